mem_fill_unit: RTL and testbench

Line-fill engine between the instruction cache control unit and external memory. It runs on a miss. It latches the miss address, issues one line-aligned read request, and collects `WORDS_PER_LINE` response beats into a line buffer. It then reports completion back to the control unit. The filled line and the missed word are presented to the array updater and the output stage.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/mem_fill_unit_line_buffer.sv | 42 ++++
 rtl/mem_fill_unit.sv | 143 ++++++++++++++
 tb/tb_mem_fill_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache fill path.
package icache_pkg;

  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned OFFSET_WIDTH   = $clog2(WORDS_PER_LINE);
  localparam int unsigned MAX_ADDR_WIDTH = 64;

  typedef enum logic [1:0] {
    FILL_IDLE    = 2'd0,
    FILL_REQ     = 2'd1,
    FILL_COLLECT = 2'd2,
    FILL_DONE    = 2'd3
  } fill_state_e;

  // Clear the word-offset bits so the address points at the start of its line.
  function automatic logic [MAX_ADDR_WIDTH-1:0] line_align(
    input logic [MAX_ADDR_WIDTH-1:0] addr,
    input int unsigned               off_w
  );
    logic [MAX_ADDR_WIDTH-1:0] mask;
    mask = {MAX_ADDR_WIDTH{1'b1}} << off_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/mem_fill_unit_line_buffer.sv
// Line buffer: one register per word, single write port, one read port plus full line view.
module line_buffer
  import icache_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        we_i,
  input  logic [IDX_W-1:0]            wr_idx_i,
  input  logic [WORD_WIDTH-1:0]       wr_data_i,
  input  logic [IDX_W-1:0]            rd_idx_i,
  output logic [WORD_WIDTH*DEPTH-1:0] line_o,
  output logic [WORD_WIDTH-1:0]       rd_word_o
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  // Word storage; cleared on reset, written one beat at a time.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Flatten the array, word k at bits [k*W +: W].
  always_comb begin
    line_o = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      line_o[k*WORD_WIDTH +: WORD_WIDTH] = mem_q[k];
    end
  end

  assign rd_word_o = mem_q[rd_idx_i];

endmodule

// File: rtl/mem_fill_unit.sv
// Line-fill engine: one aligned read request per miss, collects a line, hands it back.
module mem_fill_unit #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                                 clk,
  input  logic                                 arst_n,
  input  logic                                 i_halt,
  input  logic                                 i_initiate_mem_req,
  input  logic [ADDR_WIDTH-1:0]                i_miss_addr,
  input  logic                                 i_ready,
  output logic                                 o_mem_data_received,
  output logic                                 o_valid,
  output logic                                 o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]                o_mem_req_addr,
  input  logic                                 i_mem_req_ready,
  input  logic                                 i_mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0]                i_mem_rsp_data,
  output logic                                 o_mem_rsp_ready,
  output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] o_line_data,
  output logic [ADDR_WIDTH-1:0]                o_line_tag_addr,
  output logic [WORD_WIDTH-1:0]                o_missed_word
);

  import icache_pkg::*;

  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned LINE_W = WORD_WIDTH * WORDS_PER_LINE;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  fill_state_e           state_q, state_d;
  logic [OFF_W-1:0]      cnt_q, cnt_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic [ADDR_WIDTH-1:0] tag_q, tag_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  beat_accept;
  logic [LINE_W-1:0]     line;
  logic [WORD_WIDTH-1:0] rd_word;

  assign req_addr = ADDR_WIDTH'(line_align(MAX_ADDR_WIDTH'(miss_addr_q), OFF_W));

  // State, counter, address and completion registers; everything holds under halt.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= FILL_IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      miss_addr_q <= '0;
      tag_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      miss_addr_q <= miss_addr_d;
      tag_q       <= tag_d;
      done_q      <= done_d;
    end
  end

  // Next-state and handshake outputs; tag and miss offset move on the first beat so
  // the previous line stays coherent until new data actually lands.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    miss_addr_d = miss_addr_q;
    tag_d       = tag_q;
    done_d      = done_q;
    beat_accept = 1'b0;

    o_mem_req_valid = (state_q == FILL_REQ);
    o_mem_req_addr  = o_mem_req_valid ? req_addr : '0;
    o_mem_rsp_ready = (state_q == FILL_COLLECT) && !i_halt;

    if (!i_halt) begin
      unique case (state_q)
        FILL_IDLE: begin
          if (i_initiate_mem_req) begin
            miss_addr_d = i_miss_addr;
            cnt_d       = '0;
            state_d     = FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (i_mem_req_ready) begin
            state_d = FILL_COLLECT;
          end
        end
        FILL_COLLECT: begin
          if (i_mem_rsp_valid) begin
            beat_accept = 1'b1;
            if (cnt_q == '0) begin
              tag_d = req_addr;
              off_d = miss_addr_q[OFF_W-1:0];
            end
            if (cnt_q == LAST_BEAT) begin
              cnt_d   = '0;
              state_d = FILL_DONE;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + OFF_W'(1);
            end
          end
        end
        FILL_DONE: begin
          if (i_ready) begin
            state_d = FILL_IDLE;
            done_d  = 1'b0;
          end
        end
        default: begin
          state_d = FILL_IDLE;
        end
      endcase
    end
  end

  line_buffer #(
    .WORD_WIDTH(WORD_WIDTH),
    .DEPTH     (WORDS_PER_LINE),
    .IDX_W     (OFF_W)
  ) u_line_buffer (
    .clk      (clk),
    .arst_n   (arst_n),
    .we_i     (beat_accept),
    .wr_idx_i (cnt_q),
    .wr_data_i(i_mem_rsp_data),
    .rd_idx_i (off_q),
    .line_o   (line),
    .rd_word_o(rd_word)
  );

  assign o_mem_data_received = done_q;
  assign o_valid             = done_q;
  assign o_line_tag_addr     = tag_q;
  assign o_missed_word       = rd_word;
  assign o_line_data         = line;

endmodule

// File: tb/tb_mem_fill_unit.sv
// Randomized bench for mem_fill_unit with a line-level reference model.
module tb_mem_fill_unit;

  localparam int unsigned AW = 16;
  localparam int unsigned WW = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned LW = WW * N;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          i_halt = 1'b0;
  logic          i_initiate_mem_req = 1'b0;
  logic [AW-1:0] i_miss_addr = '0;
  logic          i_ready = 1'b0;
  logic          o_mem_data_received;
  logic          o_valid;
  logic          o_mem_req_valid;
  logic [AW-1:0] o_mem_req_addr;
  logic          i_mem_req_ready = 1'b0;
  logic          i_mem_rsp_valid = 1'b0;
  logic [WW-1:0] i_mem_rsp_data = '0;
  logic          o_mem_rsp_ready;
  logic [LW-1:0] o_line_data;
  logic [AW-1:0] o_line_tag_addr;
  logic [WW-1:0] o_missed_word;

  int vectors = 0;
  int miscompares = 0;

  logic [WW-1:0] beats [N];

  // Results of the most recent do_fill run.
  int            r_done, r_idle, r_last_acc, r_req_acc, r_addr_bad;
  int            r_halt_bad, r_valid_bad, r_done_hi;
  bit            r_timeout;
  logic [AW-1:0] r_req_addr;

  always #5 clk = ~clk;

  mem_fill_unit #(
    .ADDR_WIDTH    (AW),
    .WORD_WIDTH    (WW),
    .WORDS_PER_LINE(N)
  ) dut (
    .clk                (clk),
    .arst_n             (arst_n),
    .i_halt             (i_halt),
    .i_initiate_mem_req (i_initiate_mem_req),
    .i_miss_addr        (i_miss_addr),
    .i_ready            (i_ready),
    .o_mem_data_received(o_mem_data_received),
    .o_valid            (o_valid),
    .o_mem_req_valid    (o_mem_req_valid),
    .o_mem_req_addr     (o_mem_req_addr),
    .i_mem_req_ready    (i_mem_req_ready),
    .i_mem_rsp_valid    (i_mem_rsp_valid),
    .i_mem_rsp_data     (i_mem_rsp_data),
    .o_mem_rsp_ready    (o_mem_rsp_ready),
    .o_line_data        (o_line_data),
    .o_line_tag_addr    (o_line_tag_addr),
    .o_missed_word      (o_missed_word)
  );

  function automatic logic [LW-1:0] model_line();
    logic [LW-1:0] l;
    for (int k = 0; k < int'(N); k++) l[k*WW +: WW] = beats[k];
    return l;
  endfunction

  function automatic logic [AW-1:0] model_align(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    m = ~AW'(N - 1);
    return a & m;
  endfunction

  task automatic new_beats();
    for (int k = 0; k < int'(N); k++) beats[k] = $urandom;
  endtask

  // Drives one fill, acting as control unit and memory; records what it observes.
  // Cycle 0 is the initiate cycle; memory keeps its offers pending while halted.
  task automatic do_fill(input logic [AW-1:0] addr, input int req_delay, input bit gaps,
                         input int halt_at, input int halt_len, input int ready_delay,
                         input int reinit_at);
    int c;
    int bi;
    bit rv;
    bit h;
    bit seen;
    r_done = -1; r_idle = -1; r_last_acc = -1; r_req_acc = 0; r_addr_bad = 0;
    r_halt_bad = 0; r_valid_bad = 0; r_done_hi = 0; r_timeout = 0; r_req_addr = 'x;
    bi = 0; rv = 1'b0; seen = 1'b0;
    i_initiate_mem_req = 1'b1; i_miss_addr = addr; i_halt = 1'b0;
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_ready = 1'b0;
    @(posedge clk); #1;
    i_initiate_mem_req = 1'b0;
    for (c = 1; c < 300; c++) begin
      if (o_mem_data_received) begin
        r_done_hi++;
        if (r_done < 0) r_done = c;
      end else if (r_done >= 0) begin
        r_idle = c;
        break;
      end
      h = (c >= halt_at) && (c < halt_at + halt_len);
      i_halt = h;
      i_initiate_mem_req = (c == reinit_at);
      if (c == reinit_at) i_miss_addr = ~addr;
      i_mem_req_ready = (c >= 1 + req_delay);
      if (!h) rv = (bi < int'(N)) && (gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
      else    rv = rv && (bi < int'(N));
      i_mem_rsp_valid = rv;
      i_mem_rsp_data = (bi < int'(N)) ? beats[bi] : '0;
      i_ready = (r_done >= 0) && (c >= r_done + ready_delay);
      #1;
      if (o_valid !== o_mem_data_received) r_valid_bad++;
      if (o_mem_req_valid) begin
        if (!seen) begin r_req_addr = o_mem_req_addr; seen = 1'b1; end
        else if (o_mem_req_addr !== r_req_addr) r_addr_bad++;
        if (i_mem_req_ready && !h) r_req_acc++;
      end
      if (h && o_mem_rsp_ready) r_halt_bad++;
      if (rv && o_mem_rsp_ready) begin bi++; r_last_acc = c; end
      @(posedge clk); #1;
    end
    if (r_idle < 0) r_timeout = 1'b1;
    i_halt = 1'b0; i_initiate_mem_req = 1'b0; i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0; i_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (o_mem_data_received !== 1'b0 || o_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_done: got %b/%b expected 0/0", o_mem_data_received, o_valid); end
    vectors++; if (o_mem_req_valid !== 1'b0 || o_mem_req_addr !== '0) begin miscompares++;
      $display("FAIL reset_req: got %b/%h expected 0/0", o_mem_req_valid, o_mem_req_addr); end
    vectors++; if (o_mem_rsp_ready !== 1'b0) begin miscompares++;
      $display("FAIL reset_rsp_ready: got %b expected 0", o_mem_rsp_ready); end
    vectors++; if (o_line_data !== '0 || o_line_tag_addr !== '0 || o_missed_word !== '0) begin miscompares++;
      $display("FAIL reset_line: got %h/%h/%h expected 0", o_line_data, o_line_tag_addr, o_missed_word); end
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (o_mem_req_valid !== 1'b0 || o_mem_data_received !== 1'b0) begin miscompares++;
      $display("FAIL reset_idle: got %b/%b expected 0/0", o_mem_req_valid, o_mem_data_received); end
  endtask

  task automatic test_basic_fill();
    for (int k = 0; k < int'(N); k++) beats[k] = 32'hA0 + 32'(k);
    do_fill(16'h1236, 0, 1'b0, 1000, 0, 0, -1);
    vectors++; if (r_timeout) begin miscompares++; $display("FAIL basic_timeout: got timeout expected completion"); end
    vectors++; if (r_req_addr !== 16'h1234) begin miscompares++;
      $display("FAIL basic_req_addr: got %h expected 1234", r_req_addr); end
    vectors++; if (r_done !== 6) begin miscompares++;
      $display("FAIL basic_done_cycle: got %0d expected 6", r_done); end
    vectors++; if (r_idle !== 7) begin miscompares++;
      $display("FAIL basic_idle_cycle: got %0d expected 7", r_idle); end
    vectors++; if (o_line_data !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin miscompares++;
      $display("FAIL basic_line: got %h expected a3_a2_a1_a0", o_line_data); end
    vectors++; if (o_missed_word !== 32'hA2) begin miscompares++;
      $display("FAIL basic_missed_word: got %h expected a2", o_missed_word); end
    vectors++; if (o_line_tag_addr !== 16'h1234) begin miscompares++;
      $display("FAIL basic_tag: got %h expected 1234", o_line_tag_addr); end
  endtask

  task automatic test_req_backpressure();
    new_beats();
    do_fill(16'hBEEF, 5, 1'b0, 1000, 0, 0, -1);
    vectors++; if (r_req_acc !== 1) begin miscompares++;
      $display("FAIL bp_req_count: got %0d expected 1", r_req_acc); end
    vectors++; if (r_addr_bad !== 0 || r_req_addr !== 16'hBEEC) begin miscompares++;
      $display("FAIL bp_req_addr: got %h (%0d changes) expected beec stable", r_req_addr, r_addr_bad); end
    vectors++; if (r_done !== 11) begin miscompares++;
      $display("FAIL bp_done_cycle: got %0d expected 11", r_done); end
    vectors++; if (o_line_data !== model_line() || o_missed_word !== beats[3]) begin miscompares++;
      $display("FAIL bp_line: got %h/%h expected %h/%h", o_line_data, o_missed_word, model_line(), beats[3]); end
  endtask

  task automatic test_gapped_halt();
    new_beats();
    do_fill(16'h0ABD, 0, 1'b1, 4, 3, 0, -1);
    vectors++; if (r_timeout) begin miscompares++; $display("FAIL gap_timeout: got timeout expected completion"); end
    vectors++; if (r_halt_bad !== 0) begin miscompares++;
      $display("FAIL gap_rsp_ready_in_halt: got %0d cycles high expected 0", r_halt_bad); end
    vectors++; if (o_line_data !== model_line()) begin miscompares++;
      $display("FAIL gap_line: got %h expected %h", o_line_data, model_line()); end
    vectors++; if (o_missed_word !== beats[1] || o_line_tag_addr !== 16'h0ABC) begin miscompares++;
      $display("FAIL gap_missed_tag: got %h/%h expected %h/0abc", o_missed_word, o_line_tag_addr, beats[1]); end
    vectors++; if (r_done !== r_last_acc + 1) begin miscompares++;
      $display("FAIL gap_done_cycle: got %0d expected %0d", r_done, r_last_acc + 1); end
  endtask

  task automatic test_done_handshake();
    int stray;
    logic [LW-1:0] held;
    new_beats();
    do_fill(16'h4C0B, 0, 1'b0, 1000, 0, 4, 3);
    vectors++; if (r_done_hi !== 5 || r_valid_bad !== 0) begin miscompares++;
      $display("FAIL hs_done_high: got %0d cycles (%0d valid diffs) expected 5 (0)", r_done_hi, r_valid_bad); end
    vectors++; if (r_idle !== r_done + 5) begin miscompares++;
      $display("FAIL hs_exit_cycle: got %0d expected %0d", r_idle, r_done + 5); end
    vectors++; if (r_req_acc !== 1 || o_line_tag_addr !== 16'h4C08) begin miscompares++;
      $display("FAIL hs_reinit_ignored: got %0d reqs tag %h expected 1 reqs tag 4c08", r_req_acc, o_line_tag_addr); end
    vectors++; if (o_line_data !== model_line() || o_missed_word !== beats[3]) begin miscompares++;
      $display("FAIL hs_line: got %h/%h expected %h/%h", o_line_data, o_missed_word, model_line(), beats[3]); end
    held = o_line_data;
    stray = 0;
    for (int c = 0; c < 3; c++) begin
      i_mem_rsp_valid = 1'b1; i_mem_rsp_data = $urandom; #1;
      if (o_mem_req_valid || o_mem_rsp_ready || o_mem_data_received) stray++;
      @(posedge clk); #1;
    end
    i_mem_rsp_valid = 1'b0;
    vectors++; if (stray !== 0 || o_line_data !== held) begin miscompares++;
      $display("FAIL hs_idle_hold: got %0d active cycles line %h expected 0 line %h", stray, o_line_data, held); end
  endtask

  task automatic test_reset_mid_collect();
    int bi;
    int bad;
    new_beats();
    bi = 0;
    i_initiate_mem_req = 1'b1; i_miss_addr = 16'h5678; i_mem_req_ready = 1'b1;
    @(posedge clk); #1;
    i_initiate_mem_req = 1'b0;
    for (int c = 0; c < 20 && bi < 2; c++) begin
      i_mem_rsp_valid = 1'b1; i_mem_rsp_data = beats[bi]; #1;
      if (o_mem_rsp_ready) bi++;
      @(posedge clk); #1;
    end
    vectors++; if (bi !== 2 || o_line_data[2*WW-1:0] !== {beats[1], beats[0]}) begin miscompares++;
      $display("FAIL rst_partial: got %0d beats low %h expected 2 beats %h", bi, o_line_data[2*WW-1:0], {beats[1], beats[0]}); end
    i_mem_rsp_data = beats[2];
    arst_n = 1'b0; #1;
    vectors++; if (o_mem_req_valid !== 1'b0 || o_mem_rsp_ready !== 1'b0 || o_mem_data_received !== 1'b0 || o_valid !== 1'b0) begin miscompares++;
      $display("FAIL rst_ctrl_zero: got %b%b%b%b expected 0000", o_mem_req_valid, o_mem_rsp_ready, o_mem_data_received, o_valid); end
    vectors++; if (o_line_data !== '0 || o_line_tag_addr !== '0 || o_missed_word !== '0) begin miscompares++;
      $display("FAIL rst_data_zero: got %h/%h/%h expected 0", o_line_data, o_line_tag_addr, o_missed_word); end
    @(posedge clk); @(posedge clk); #1;
    arst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (o_mem_rsp_ready || o_mem_req_valid || o_mem_data_received) bad++;
      @(posedge clk); #1;
    end
    vectors++; if (bad !== 0 || o_line_data !== '0) begin miscompares++;
      $display("FAIL rst_late_beats: got %0d active cycles line %h expected 0", bad, o_line_data); end
    i_mem_rsp_valid = 1'b0; i_mem_req_ready = 1'b0;
    new_beats();
    do_fill(16'h0000, 0, 1'b0, 1000, 0, 0, -1);
    vectors++; if (r_done !== 6 || o_line_data !== model_line() || o_missed_word !== beats[0] || o_line_tag_addr !== 16'h0000) begin miscompares++;
      $display("FAIL rst_refill: got done %0d line %h word %h expected 6 %h %h", r_done, o_line_data, o_missed_word, model_line(), beats[0]); end
  endtask

  task automatic test_random_fills();
    logic [AW-1:0] a;
    int rd;
    int yd;
    bit g;
    for (int t = 0; t < 8; t++) begin
      new_beats();
      a = AW'($urandom);
      rd = $urandom_range(0, 3);
      yd = $urandom_range(0, 3);
      g = ($urandom_range(0, 1) == 1);
      do_fill(a, rd, g, 1000, 0, yd, -1);
      vectors++; if (r_timeout || r_req_acc !== 1 || r_addr_bad !== 0 || r_req_addr !== model_align(a)) begin miscompares++;
        $display("FAIL rand_req[%0d]: got to=%0b n=%0d addr %h expected 1 req addr %h", t, r_timeout, r_req_acc, r_req_addr, model_align(a)); end
      vectors++; if (o_line_data !== model_line() || o_missed_word !== beats[a % AW'(N)] || o_line_tag_addr !== model_align(a)) begin miscompares++;
        $display("FAIL rand_line[%0d]: got %h/%h/%h expected %h/%h/%h", t, o_line_data, o_missed_word, o_line_tag_addr,
                 model_line(), beats[a % AW'(N)], model_align(a)); end
      vectors++; if (r_done !== r_last_acc + 1 || r_idle !== r_done + yd + 1) begin miscompares++;
        $display("FAIL rand_timing[%0d]: got done %0d idle %0d expected %0d %0d", t, r_done, r_idle, r_last_acc + 1, r_done + yd + 1); end
      if (!g) begin
        vectors++; if (r_done !== 2 + int'(N) + rd) begin miscompares++;
          $display("FAIL rand_latency[%0d]: got %0d expected %0d", t, r_done, 2 + int'(N) + rd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_req_backpressure();
    test_gapped_halt();
    test_done_handshake();
    test_reset_mid_collect();
    test_random_fills();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
